wide_add_sequencer: RTL and testbench
=====================================

// Module: wide_add_sequencer
// PURPOSE
//  Multi-cycle controller that computes a wide (N*K-bit) sum on one shared N-bit generic_adder.
//  One N-bit chunk is processed per cycle, LSB chunk first, with the carry registered between chunks.
//  Sits between the ALU issue logic and wide-operand consumers, trading latency for adder area.
//  Uses a valid/ready handshake on both the operand side and the result side.
// PARAMETERS
//  N  20  chunk width; width of the shared generic_adder
//  K  4   chunks per operation (K>=2); operand width W = N*K
// PORTS
//  clk        in   1    clock; all state updates on posedge
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    operands a, b and carry_in are presented
//  in_ready   out  1    block can accept an operation (asserted only in IDLE)
//  a          in   W    operand A
//  b          in   W    operand B
//  carry_in   in   1    carry into chunk 0
//  op_sub     in   1    subtract request; present only with WAS_SUBTRACT_EN
//  res_valid  out  1    s, carry_out and ovf are valid
//  res_ready  in   1    consumer takes the result
//  s          out  W    sum
//  carry_out  out  1    carry out of chunk K-1
//  ovf        out  1    two's-complement overflow of the W-bit result
// BEHAVIOUR
//  Reset: state=IDLE, chunk index=0, carry reg=0, s=0, carry_out=0, ovf=0, res_valid=0, in_ready=1.
//  FSM states: IDLE, RUN, DONE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&&in_ready: latch a, b (b_eff), and carry_in into the carry reg; set index=0; go to RUN.
//   - Inputs are sampled only at this handshake; later input changes are ignored.
//  RUN:
//   - Each cycle: adder input = a[idx*N +: N], b_eff[idx*N +: N], carry reg.
//   - Adder output is written to s[idx*N +: N]; adder carry_out updates the carry reg.
//   - idx increments; on idx==K-1: capture carry_out and ovf, then go to DONE.
//   - s is not meaningful while res_valid=0.
//  DONE:
//   - res_valid=1; s, carry_out and ovf are held stable.
//   - On res_ready: go to IDLE (res_valid drops next cycle).
//  Latency: res_valid rises exactly K cycles after the accept edge.
//  Throughput: K+2 cycles per operation with res_ready tied high.
//  in_ready=0 in RUN and DONE; in_valid is ignored there and no operation is queued.
//  res_ready is ignored outside DONE.
//  ovf = (a[W-1]==b_eff[W-1]) && (s[W-1]!=a[W-1]), evaluated on the final chunk.
//  idx counter is $clog2(K) bits wide; no wrap occurs (exit at K-1); K that is not a power of 2 is legal.
//  rst mid-RUN/DONE: the operation is aborted; the next cycle shows the reset values. A new operation can be accepted the cycle after rst deasserts.
// CONFIGURATION
//  WAS_SUBTRACT_EN defined:
//   - op_sub port exists, latched at accept.
//   - op_sub=1: b_eff=~b and chunk-0 carry=1, so s = a-b; carry_in is ignored. carry_out=1 means no borrow.
//  WAS_SUBTRACT_EN undefined: no op_sub port; b_eff=b; add-only.
// STRUCTURE
//  Package was_pkg: state enum typedef was_state_t {IDLE,RUN,DONE}; function for the idx counter width.
//  One sub-module: a single generic_adder #(.N(N)) instance as the chunk datapath; FSM, registers and muxing stay in this module.
//  No other adders are allowed in the block.
// TESTING (N=20, K=4, W=80)
//  1. a=80'hFFFFF_FFFFF_FFFFF_FFFFF, b=1, cin=0 -> s=0, carry_out=1, ovf=0; res_valid rises 4 cycles after accept.
//  2. a=80'h00000_00000_00000_FFFFF, b=1 -> s=80'h00000_00000_00001_00000 (carry crosses chunk boundary), carry_out=0.
//  3. a=80'h7FFFF_FFFFF_FFFFF_FFFFF, b=1 -> s=80'h80000_00000_00000_00000, ovf=1, carry_out=0.
//  4. Backpressure: res_ready=0 for 10 cycles in DONE -> s/res_valid stable, in_ready=0; in_valid pulses ignored; then res_ready=1 -> IDLE.
//  5. rst asserted at RUN idx=2 -> next cycle res_valid=0, s=0, in_ready=1; a fresh op then completes correctly.
//  6. WAS_SUBTRACT_EN: a=5, b=7, op_sub=1 -> s=80'hFFFFF_FFFFF_FFFFF_FFFFE, carry_out=0; a=7, b=5 -> s=2, carry_out=1.

Source files
------------

// File: rtl/wide_add_sequencer_pkg.sv
// Package was_pkg: shared types and helpers for wide_add_sequencer.
//   was_state_t - controller states (IDLE, RUN, DONE)
//   idx_width() - width of the chunk index counter for a given chunk count
package was_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } was_state_t;

  // Index counter width; at least one bit even for degenerate K.
  function automatic int unsigned idx_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// generic_adder: N-bit ripple adder used as the shared chunk datapath.
// Ports:
//   a, b     - N-bit addends
//   cin      - carry in
//   sum_c    - N-bit sum (combinational)
//   cout_c   - carry out (combinational)
module generic_adder #(
  parameter int unsigned N = 20
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum_c,
  output logic         cout_c
);

  logic [N:0] full_c;

  assign full_c = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
  assign sum_c  = full_c[N-1:0];
  assign cout_c = full_c[N];

endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: computes a W = N*K bit sum one N-bit chunk per cycle
// on a single shared generic_adder, LSB chunk first, carry registered
// between chunks. Valid/ready handshake on operand and result sides.
// Optional macro WAS_SUBTRACT_EN adds the op_sub port (s = a - b).
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - operand handshake (in_ready only in IDLE)
//   a, b, carry_in      - W-bit operands and carry into chunk 0
//   op_sub              - subtract request (WAS_SUBTRACT_EN only)
//   res_valid, res_ready- result handshake
//   s, carry_out, ovf   - W-bit sum, final carry, signed overflow
module wide_add_sequencer
  import was_pkg::*;
#(
  parameter int unsigned N = 20,
  parameter int unsigned K = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*K-1:0]    a,
  input  logic [N*K-1:0]    b,
  input  logic              carry_in,
`ifdef WAS_SUBTRACT_EN
  input  logic              op_sub,
`endif
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N*K-1:0]    s,
  output logic              carry_out,
  output logic              ovf
);

  localparam int unsigned W  = N * K;
  localparam int unsigned IW = idx_width(K);

  was_state_t    state_q, state_d;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic [W-1:0]  a_q, b_q, s_q;
  logic          carry_out_q, ovf_q, res_valid_q, in_ready_q;

  logic          accept_c, last_c;
  logic [W-1:0]  b_eff_c;
  logic          cin_eff_c;
  logic [N-1:0]  a_chunk_c, b_chunk_c, sum_c;
  logic          cout_c;

  // Operand conditioning at accept: subtract inverts b and forces carry in.
`ifdef WAS_SUBTRACT_EN
  assign b_eff_c   = op_sub ? ~b : b;
  assign cin_eff_c = op_sub ? 1'b1 : carry_in;
`else
  assign b_eff_c   = b;
  assign cin_eff_c = carry_in;
`endif

  // Next-state and control decode.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (idx_q == IW'(K - 1)) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; handshake flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      res_valid_q <= (state_d == DONE);
    end
  end

  assign a_chunk_c = a_q[idx_q*N +: N];
  assign b_chunk_c = b_q[idx_q*N +: N];

  generic_adder #(.N(N)) u_adder (
    .a      (a_chunk_c),
    .b      (b_chunk_c),
    .cin    (carry_q),
    .sum_c  (sum_c),
    .cout_c (cout_c)
  );

  // Operand latch and chunk-serial accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (accept_c) begin
        a_q     <= a;
        b_q     <= b_eff_c;
        carry_q <= cin_eff_c;
        idx_q   <= '0;
      end
      if (state_q == RUN) begin
        s_q[idx_q*N +: N] <= sum_c;
        carry_q           <= cout_c;
        if (last_c) begin
          carry_out_q <= cout_c;
          ovf_q       <= (a_q[W-1] == b_q[W-1]) && (sum_c[N-1] != a_q[W-1]);
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign s         = s_q;
  assign carry_out = carry_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (N=20, K=4, W=80).
// Define WAS_SUBTRACT_EN on both RTL and bench to exercise subtraction.
module tb_wide_add_sequencer;

  localparam int unsigned N = 20;
  localparam int unsigned K = 4;
  localparam int unsigned W = N * K;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         carry_in;
  logic         res_valid, res_ready;
  logic [W-1:0] s;
  logic         carry_out, ovf;
`ifdef WAS_SUBTRACT_EN
  logic         op_sub;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
`ifdef WAS_SUBTRACT_EN
    .op_sub    (op_sub),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .s         (s),
    .carry_out (carry_out),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present an operation, wait for the result, check it, then consume it.
  task automatic run_op(input vec_t v, input string name);
    int cyc;
    chk({name, " in_ready_idle"}, W'(in_ready), W'(1));
    a        = v.a;
    b        = v.b;
    carry_in = v.cin;
`ifdef WAS_SUBTRACT_EN
    op_sub   = v.sub;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = '1;
    b        = '1;
    carry_in = 1'b1;
    chk({name, " in_ready_busy"}, W'(in_ready), W'(0));
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " latency"}, W'(cyc), W'(K));
    chk({name, " s"}, s, v.s);
    chk({name, " carry_out"}, W'(carry_out), W'(v.co));
    chk({name, " ovf"}, W'(ovf), W'(v.ovf));
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({name, " res_valid_drop"}, W'(res_valid), W'(0));
  endtask

  vec_t vecs[6];
  vec_t v;
  logic [W-1:0] held_s;

  initial begin
    vecs[0] = '{a: 80'hFFFFF_FFFFF_FFFFF_FFFFF, b: 80'h1, cin: 1'b0, sub: 1'b0,
                s: 80'h0, co: 1'b1, ovf: 1'b0};
    vecs[1] = '{a: 80'h00000_00000_00000_FFFFF, b: 80'h1, cin: 1'b0, sub: 1'b0,
                s: 80'h00000_00000_00001_00000, co: 1'b0, ovf: 1'b0};
    vecs[2] = '{a: 80'h7FFFF_FFFFF_FFFFF_FFFFF, b: 80'h1, cin: 1'b0, sub: 1'b0,
                s: 80'h80000_00000_00000_00000, co: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 80'h1234, b: 80'h5678, cin: 1'b1, sub: 1'b0,
                s: 80'h68AD, co: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 80'h80000_00000_00000_00000, b: 80'h80000_00000_00000_00000, cin: 1'b0,
                sub: 1'b0, s: 80'h0, co: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 80'hFFFFF_FFFFF_FFFFF_FFFFF, b: 80'hFFFFF_FFFFF_FFFFF_FFFFF, cin: 1'b1,
                sub: 1'b0, s: 80'hFFFFF_FFFFF_FFFFF_FFFFF, co: 1'b1, ovf: 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    a         = '0;
    b         = '0;
    carry_in  = 1'b0;
`ifdef WAS_SUBTRACT_EN
    op_sub    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", W'(in_ready), W'(1));
    chk("reset res_valid", W'(res_valid), W'(0));
    chk("reset s", s, '0);
    chk("reset carry_out", W'(carry_out), W'(0));
    chk("reset ovf", W'(ovf), W'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held while res_ready low, in_valid ignored.
    v = vecs[2];
    chk("bp in_ready_idle", W'(in_ready), W'(1));
    a = v.a; b = v.b; carry_in = v.cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (K) @(posedge clk);
    #1;
    chk("bp res_valid", W'(res_valid), W'(1));
    held_s = s;
    chk("bp s", held_s, v.s);
    for (int c = 0; c < 10; c++) begin
      a = 80'h5; b = 80'h5; in_valid = c[0];
      @(posedge clk); #1;
      chk($sformatf("bp hold s c%0d", c), s, v.s);
      chk($sformatf("bp hold valid c%0d", c), W'(res_valid), W'(1));
      chk($sformatf("bp hold in_ready c%0d", c), W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp release res_valid", W'(res_valid), W'(0));
    chk("bp release in_ready", W'(in_ready), W'(1));
    // No operation was queued by the ignored pulses.
    repeat (K + 1) @(posedge clk);
    #1;
    chk("bp no queued op", W'(res_valid), W'(0));

    // Reset in the middle of RUN (idx=2).
    a = vecs[0].a; b = vecs[0].b; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst res_valid", W'(res_valid), W'(0));
    chk("midrst s", s, '0);
    chk("midrst in_ready", W'(in_ready), W'(1));
    chk("midrst carry_out", W'(carry_out), W'(0));
    run_op(vecs[1], "post_rst");

`ifdef WAS_SUBTRACT_EN
    v = '{a: 80'h5, b: 80'h7, cin: 1'b0, sub: 1'b1,
          s: 80'hFFFFF_FFFFF_FFFFF_FFFFE, co: 1'b0, ovf: 1'b0};
    run_op(v, "sub5m7");
    v = '{a: 80'h7, b: 80'h5, cin: 1'b0, sub: 1'b1, s: 80'h2, co: 1'b1, ovf: 1'b0};
    run_op(v, "sub7m5");
    op_sub = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
